fft_bin_reader: RTL

Downstream consumer of the 16-point FFT output interface. It captures one parallel frame of 16 packed complex bins on `fft_valid`. It then streams the bins out one at a time in natural order over a valid/ready handshake, each with its squared magnitude. Optionally, it reports the peak non-DC bin once per frame. It sits between the FFT pipeline and the spectrum analysis/reporting logic.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_mag_sq.sv | 21 ++
 rtl/fft_bin_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, packed complex sample type and the
// reader FSM state encoding.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_IDX_W = 4;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx16_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } fft_state_e;

  // Split a {re, im} packed word into its complex fields.
  function automatic cplx16_t unpack_cplx(input logic [31:0] w);
    cplx16_t c;
    c.re = w[31:16];
    c.im = w[15:0];
    return c;
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Combinational squared magnitude of one complex sample: re*re + im*im.
// The worst case (-32768, -32768) gives 2^31, which fits the unsigned result.
module fft_mag_sq
  import fft_pkg::*;
(
  input  cplx16_t     c,
  output logic [31:0] mag
);

  logic signed [31:0] re_x_s;
  logic signed [31:0] im_x_s;
  logic signed [31:0] re_sq_s;
  logic signed [31:0] im_sq_s;

  assign re_x_s  = 32'(c.re);
  assign im_x_s  = 32'(c.im);
  assign re_sq_s = re_x_s * re_x_s;
  assign im_sq_s = im_x_s * im_x_s;
  assign mag     = $unsigned(re_sq_s) + $unsigned(im_sq_s);

endmodule

// File: rtl/fft_bin_reader.sv
// Captures a parallel 16-bin FFT frame and streams bins 0..NUM_OUT-1 with their
// squared magnitude. Peak reporting is built when FFT_BIN_READER_PEAK_DETECT_EN is defined.
module fft_bin_reader
  import fft_pkg::*;
#(
  parameter int NUM_OUT = 16,
  parameter int DROP_W  = 8
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fft_valid,
  input  logic [31:0]              fft_d00,
  input  logic [31:0]              fft_d01,
  input  logic [31:0]              fft_d02,
  input  logic [31:0]              fft_d03,
  input  logic [31:0]              fft_d04,
  input  logic [31:0]              fft_d05,
  input  logic [31:0]              fft_d06,
  input  logic [31:0]              fft_d07,
  input  logic [31:0]              fft_d08,
  input  logic [31:0]              fft_d09,
  input  logic [31:0]              fft_d10,
  input  logic [31:0]              fft_d11,
  input  logic [31:0]              fft_d12,
  input  logic [31:0]              fft_d13,
  input  logic [31:0]              fft_d14,
  input  logic [31:0]              fft_d15,
  input  logic                     bin_ready,
  output logic                     bin_valid,
  output logic [3:0]               bin_idx,
  output logic signed [15:0]       bin_re,
  output logic signed [15:0]       bin_im,
  output logic [31:0]              bin_mag,
  output logic                     bin_last,
  output logic                     busy,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     peak_valid,
  output logic [3:0]               peak_idx,
  output logic [31:0]              peak_mag
);

  localparam logic [FFT_IDX_W-1:0] LAST_IDX = FFT_IDX_W'(NUM_OUT - 1);

  logic [31:0]           frame_s [FFT_N];
  logic [31:0]           buf_r   [FFT_N];
  fft_state_e            state_r;
  fft_state_e            state_nxt_s;
  logic                  bin_valid_r;
  logic [FFT_IDX_W-1:0]  bin_idx_r;
  logic signed [15:0]    bin_re_r;
  logic signed [15:0]    bin_im_r;
  logic [31:0]           bin_mag_r;
  logic                  bin_last_r;
  logic [DROP_W-1:0]     drop_cnt_r;
  logic                  accept_s;
  logic                  last_s;
  logic                  capture_s;
  logic                  advance_s;
  logic                  drop_s;
  logic                  load_s;
  logic [FFT_IDX_W-1:0]  load_idx_s;
  logic [31:0]           load_word_s;
  cplx16_t               load_c_s;
  logic [31:0]           load_mag_s;

  assign frame_s[0]  = fft_d00;
  assign frame_s[1]  = fft_d01;
  assign frame_s[2]  = fft_d02;
  assign frame_s[3]  = fft_d03;
  assign frame_s[4]  = fft_d04;
  assign frame_s[5]  = fft_d05;
  assign frame_s[6]  = fft_d06;
  assign frame_s[7]  = fft_d07;
  assign frame_s[8]  = fft_d08;
  assign frame_s[9]  = fft_d09;
  assign frame_s[10] = fft_d10;
  assign frame_s[11] = fft_d11;
  assign frame_s[12] = fft_d12;
  assign frame_s[13] = fft_d13;
  assign frame_s[14] = fft_d14;
  assign frame_s[15] = fft_d15;

  // Next-state decode plus capture/advance/drop decisions and output-stage source select.
  always_comb begin
    accept_s    = bin_valid_r & bin_ready;
    last_s      = (bin_idx_r == LAST_IDX);
    capture_s   = 1'b0;
    drop_s      = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fft_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (accept_s && last_s) begin
          if (fft_valid) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_STREAM;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          drop_s      = fft_valid;
          state_nxt_s = ST_STREAM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    advance_s = accept_s & ~last_s;
    load_s    = capture_s | advance_s;
    // A fresh frame is not in the buffer yet, so bin 0 comes straight from the inputs.
    if (capture_s) begin
      load_idx_s  = 4'd0;
      load_word_s = fft_d00;
    end else begin
      load_idx_s  = bin_idx_r + 4'd1;
      load_word_s = buf_r[load_idx_s];
    end
  end

  assign load_c_s = unpack_cplx(load_word_s);

  fft_mag_sq u_mag_sq (
    .c   (load_c_s),
    .mag (load_mag_s)
  );

  // Frame buffer capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FFT_N; k++) begin
        buf_r[k] <= 32'd0;
      end
    end else if (capture_s) begin
      for (int k = 0; k < FFT_N; k++) begin
        buf_r[k] <= frame_s[k];
      end
    end
  end

  // FSM state, registered output stage and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      bin_valid_r <= 1'b0;
      bin_idx_r   <= 4'd0;
      bin_re_r    <= 16'sd0;
      bin_im_r    <= 16'sd0;
      bin_mag_r   <= 32'd0;
      bin_last_r  <= 1'b0;
      drop_cnt_r  <= {DROP_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      bin_valid_r <= (state_nxt_s == ST_STREAM);
      if (load_s) begin
        bin_idx_r  <= load_idx_s;
        bin_re_r   <= load_c_s.re;
        bin_im_r   <= load_c_s.im;
        bin_mag_r  <= load_mag_s;
        bin_last_r <= (load_idx_s == LAST_IDX);
      end
      if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + {{(DROP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bin_valid = bin_valid_r;
  assign bin_idx   = bin_idx_r;
  assign bin_re    = bin_re_r;
  assign bin_im    = bin_im_r;
  assign bin_mag   = bin_mag_r;
  assign bin_last  = bin_last_r;
  assign busy      = (state_r == ST_STREAM);
  assign drop_cnt  = drop_cnt_r;

`ifdef FFT_BIN_READER_PEAK_DETECT_EN
  logic [31:0]          max_mag_r;
  logic [FFT_IDX_W-1:0] max_idx_r;
  logic                 peak_valid_r;
  logic [FFT_IDX_W-1:0] peak_idx_r;
  logic [31:0]          peak_mag_r;
  logic                 take_s;
  logic [31:0]          run_mag_s;
  logic [FFT_IDX_W-1:0] run_idx_s;

  // Running max over accepted bins; bin 1 seeds it so an all-zero frame reports bin 1.
  always_comb begin
    take_s = accept_s && (bin_idx_r != 4'd0) &&
             ((bin_idx_r == 4'd1) || (bin_mag_r > max_mag_r));
    if (take_s) begin
      run_mag_s = bin_mag_r;
      run_idx_s = bin_idx_r;
    end else begin
      run_mag_s = max_mag_r;
      run_idx_s = max_idx_r;
    end
  end

  // Running max state and end-of-frame peak report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_mag_r    <= 32'd0;
      max_idx_r    <= 4'd0;
      peak_valid_r <= 1'b0;
      peak_idx_r   <= 4'd0;
      peak_mag_r   <= 32'd0;
    end else begin
      max_mag_r    <= run_mag_s;
      max_idx_r    <= run_idx_s;
      peak_valid_r <= accept_s & last_s;
      if (accept_s && last_s) begin
        peak_idx_r <= run_idx_s;
        peak_mag_r <= run_mag_s;
      end
    end
  end

  assign peak_valid = peak_valid_r;
  assign peak_idx   = peak_idx_r;
  assign peak_mag   = peak_mag_r;
`else
  assign peak_valid = 1'b0;
  assign peak_idx   = 4'd0;
  assign peak_mag   = 32'd0;
`endif

endmodule
